// File: rtl/seq_divmod_select.sv
// ---------------------------------------------------------------------------
// seq_divmod_select
//
// Multicycle signed divide / modulo / select datapath.
//   e = a / b, g = a % b, f = c / d   (two radix-2 restoring dividers)
//   z = (g == zero) ? e : f           (registered)
// One operation is in flight at a time; the dividers share one controller.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is high only in IDLE; out_valid stays high, with z held
// stable, until out_ready is seen; there is no same-cycle turnaround.
//
// Optional build macro: SEQ_DIVMOD_DZ_FLAG_EN adds output dz, which flags
// that the divisor feeding the selected result was zero.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set a, b, c, d, zero is valid
//   in_ready   block can accept an operand set
//   a, b       signed dividend / divisor for e and g
//   c, d       signed dividend / divisor for f
//   zero       signed compare value for g
//   out_valid  z holds a completed result
//   out_ready  consumer accepts z
//   z          registered signed result
//   dz         (SEQ_DIVMOD_DZ_FLAG_EN only) selected divisor was zero
// ---------------------------------------------------------------------------
module seq_divmod_select #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] z
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
    ,
    output logic                 dz
`endif
);

    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Divisor magnitudes are kept W+1 bits wide so |most-negative| is exact.
    logic [W:0]    abs_b, abs_d;
    // Quotient registers start as the dividend magnitude and shift left;
    // a W-bit unsigned field already holds |most-negative| = 2^(W-1).
    logic [W-1:0]  q_a, q_c;
    // Partial remainders always stay below the divisor, so W bits suffice.
    logic [W-1:0]  r_a, r_c;
    logic          sa, sb, sc, sd;
    logic [W-1:0]  a_r, zero_r;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    // One restoring step for each divider.
    logic [W:0] trial_a, trial_c;
    logic       ge_a, ge_c;

    assign trial_a = {r_a, q_a[W-1]};
    assign trial_c = {r_c, q_c[W-1]};
    assign ge_a    = (trial_a >= abs_b);
    assign ge_c    = (trial_c >= abs_d);

    // Sign fix-up and divide-by-zero overrides, used in FIN.
    logic          b_is_zero, d_is_zero, sel_e;
    logic [W-1:0]  e_val, f_val, g_val;

    always_comb begin
        b_is_zero = (abs_b == '0);
        d_is_zero = (abs_d == '0);
        e_val     = (sa ^ sb) ? (~q_a + 1'b1) : q_a;
        g_val     = sa ? (~r_a + 1'b1) : r_a;
        f_val     = (sc ^ sd) ? (~q_c + 1'b1) : q_c;
        if (b_is_zero) begin
            e_val = '1;
            g_val = a_r;
        end
        if (d_is_zero) begin
            f_val = '1;
        end
        sel_e = (g_val == zero_r);
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            abs_b     <= '0;
            abs_d     <= '0;
            q_a       <= '0;
            q_c       <= '0;
            r_a       <= '0;
            r_c       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            sc        <= 1'b0;
            sd        <= 1'b0;
            a_r       <= '0;
            zero_r    <= '0;
            z         <= '0;
            out_valid <= 1'b0;
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
            dz        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        abs_b  <= {1'b0, mag(b)};
                        abs_d  <= {1'b0, mag(d)};
                        q_a    <= mag(a);
                        q_c    <= mag(c);
                        r_a    <= '0;
                        r_c    <= '0;
                        sa     <= a[W-1];
                        sb     <= b[W-1];
                        sc     <= c[W-1];
                        sd     <= d[W-1];
                        a_r    <= a;
                        zero_r <= zero;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    r_a <= ge_a ? W'(trial_a - abs_b) : trial_a[W-1:0];
                    r_c <= ge_c ? W'(trial_c - abs_d) : trial_c[W-1:0];
                    q_a <= {q_a[W-2:0], ge_a};
                    q_c <= {q_c[W-2:0], ge_c};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    z         <= sel_e ? e_val : f_val;
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
                    dz        <= sel_e ? b_is_zero : d_is_zero;
`endif
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divmod_select.sv
// ---------------------------------------------------------------------------
// tb_seq_divmod_select
//
// Self-checking bench for seq_divmod_select at DATAWIDTH = 8.
// Expected z (and dz when SEQ_DIVMOD_DZ_FLAG_EN is defined) is computed by a
// behavioural model when an operand set is accepted, pushed to a queue and
// popped when out_valid appears. Handshake timing, stall stability and
// mid-operation reset are checked alongside.
// ---------------------------------------------------------------------------
module tb_seq_divmod_select;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, c, d, zero;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
    logic         dz;
`endif

    seq_divmod_select #(.DATAWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
        ,
        .dz        (dz)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_dz_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: Verilog signed / and % with the zero-divisor
    // and most-negative / -1 cases spelled out.
    function automatic logic [W-1:0] model_z(input logic signed [W-1:0] ma, input logic signed [W-1:0] mb,
                                             input logic signed [W-1:0] mc, input logic signed [W-1:0] md,
                                             input logic signed [W-1:0] mzero, output logic mdz);
        logic signed [W-1:0] e, f, g;
        if (mb == 0) begin
            e = 8'hFF;
            g = ma;
        end else if (ma == 8'sh80 && mb == 8'shFF) begin
            e = 8'h80;
            g = 8'h00;
        end else begin
            e = ma / mb;
            g = ma % mb;
        end
        if (md == 0)                          f = 8'hFF;
        else if (mc == 8'sh80 && md == 8'shFF) f = 8'h80;
        else                                  f = mc / md;
        if (g == mzero) begin
            mdz = (mb == 0);
            return e;
        end
        mdz = (md == 0);
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_operands;
        a    = W'($urandom_range(0, 255));
        b    = W'($urandom_range(0, 255));
        c    = W'($urandom_range(0, 255));
        d    = W'($urandom_range(0, 255));
        zero = W'($urandom_range(0, 255));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] tc, input logic [W-1:0] td, input logic [W-1:0] tz,
                          input int stall);
        logic [W-1:0] ez;
        logic         edz;
        logic [W-1:0] held_z;
        int           n;
        int           stall_bad;
        ez = model_z(ta, tb_v, tc, td, tz, edz);
        check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; c = tc; d = td; zero = tz;
        in_valid = 1'b1;
        tick;
        exp_q.push_back(ez);
        exp_dz_q.push_back(edz);
        in_valid = 1'b0;
        scramble_operands;
        n = 0;
        stall_bad = 0;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) stall_bad++;
            tick;
            n++;
        end
        check({name, "_busy_in_ready"}, 32'(stall_bad), 32'd0);
        check({name, "_latency"}, 32'(n), 32'(W + 1));
        if (exp_q.size() > 0) begin
            ez  = exp_q.pop_front();
            edz = exp_dz_q.pop_front();
            check({name, "_z"}, 32'(z), 32'(ez));
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
            check({name, "_dz"}, 32'(dz), 32'(edz));
`endif
        end
        held_z = z;
        stall_bad = 0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            scramble_operands;
            tick;
            if (z !== held_z || out_valid !== 1'b1 || in_ready !== 1'b0) stall_bad++;
        end
        if (stall > 0) check({name, "_stall_stable"}, 32'(stall_bad), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({name, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
        check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int spurious;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0; zero = '0;
        repeat (3) tick;
        rst = 1'b0;
        check("reset_z", 32'(z), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SEQ_DIVMOD_DZ_FLAG_EN
        check("reset_dz", 32'(dz), 32'd0);
`endif

        run_op("equal",    8'd7,   8'd2,   8'd20,  8'd3, 8'd1, 0);
        check("equal_const_z", 32'(z), 32'h03);
        run_op("negative", 8'hF9,  8'd2,   8'hEC,  8'd3, 8'd0, 0);
        check("negative_const_z", 32'(z), 32'hFA);
        run_op("divzero",  8'd5,   8'd0,   8'd9,   8'd4, 8'd5, 0);
        check("divzero_const_z", 32'(z), 32'hFF);
        run_op("divzero2", 8'd5,   8'd0,   8'd9,   8'd4, 8'd0, 0);
        check("divzero2_const_z", 32'(z), 32'h02);
        run_op("overflow", 8'h80,  8'hFF,  8'd1,   8'd1, 8'd0, 0);
        check("overflow_const_z", 32'(z), 32'h80);
        run_op("cdivzero", 8'd100, 8'hF9,  8'h80,  8'd0, 8'd3, 0);
        run_op("backpres", 8'd100, 8'hF9,  8'hC4,  8'd5, 8'd2, 5);
        run_op("after_bp", 8'h81,  8'd10,  8'd127, 8'h80, 8'hF9, 0);

        for (int i = 0; i < 8; i++) begin
            run_op("random", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        // Leave a known non-zero result in z, then abort an operation.
        run_op("pre_rst",  8'd7,   8'd2,   8'd20,  8'd3, 8'd1, 0);
        a = 8'd50; b = 8'd7; c = 8'd9; d = 8'd2; zero = 8'd1;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_z", 32'(z), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (out_valid !== 1'b0) spurious++;
        end
        check("midrst_no_spurious", 32'(spurious), 32'd0);
        run_op("post_rst", 8'd50,  8'd7,   8'd9,   8'd2, 8'd1, 0);
        check("post_rst_const_z", 32'(z), 32'h07);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
